// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, reads the combinational program ROM and
// feeds a 2-entry instruction buffer to the decoder over a valid/ready handshake.
module fetch_controller #(
  parameter int ADDR_W    = 4,
  parameter int INST_W    = 16,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic [1:0]        buf_count
);

  localparam logic [3:0]        OP_JMP   = 4'b1000;
  localparam logic [1:0]        CNT_FULL = 2'(BUF_DEPTH);
  localparam logic [ADDR_W-1:0] PC_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] pc_r, pc_next_s;
  logic [1:0]        count_r, count_next_s;
  logic              valid_r;
  logic [INST_W-1:0] e0_inst_r, e0_inst_next_s, e1_inst_r, e1_inst_next_s;
  logic [ADDR_W-1:0] e0_pc_r, e0_pc_next_s, e1_pc_r, e1_pc_next_s;
  logic              pop_s, fetch_s, is_jmp_s;

  assign pop_s    = valid_r & inst_ready;
  assign fetch_s  = ~halt & ~redirect_valid & ((count_r != CNT_FULL) | pop_s);
  assign is_jmp_s = (rom_inst[INST_W-1 -: 4] == OP_JMP);

  // Next-PC selection: redirect, then early JMP, then sequential, else hold.
  always_comb begin
    pc_next_s = pc_r;
    if (redirect_valid) begin
      pc_next_s = redirect_addr;
    end else if (fetch_s && is_jmp_s) begin
      pc_next_s = rom_inst[8 +: ADDR_W];
    end else if (fetch_s) begin
      pc_next_s = pc_r + PC_ONE;
    end else begin
      pc_next_s = pc_r;
    end
  end

  // Buffer next state; entry 0 is the head. Empty entries keep stale data on purpose.
  always_comb begin
    e0_inst_next_s = e0_inst_r;
    e0_pc_next_s   = e0_pc_r;
    e1_inst_next_s = e1_inst_r;
    e1_pc_next_s   = e1_pc_r;
    count_next_s   = count_r;
    if (redirect_valid) begin
      count_next_s = 2'd0;
    end else begin
      if (pop_s && (count_r == CNT_FULL)) begin
        e0_inst_next_s = e1_inst_r;
        e0_pc_next_s   = e1_pc_r;
      end else begin
        e0_inst_next_s = e0_inst_r;
        e0_pc_next_s   = e0_pc_r;
      end
      // Push lands in the first slot that is free once any pop has taken effect.
      if (fetch_s) begin
        if ((count_r == 2'd0) || ((count_r == 2'd1) && pop_s)) begin
          e0_inst_next_s = rom_inst;
          e0_pc_next_s   = pc_r;
        end else begin
          e1_inst_next_s = rom_inst;
          e1_pc_next_s   = pc_r;
        end
      end else begin
        e1_inst_next_s = e1_inst_r;
        e1_pc_next_s   = e1_pc_r;
      end
      case ({fetch_s, pop_s})
        2'b10:   count_next_s = count_r + 2'd1;
        2'b01:   count_next_s = count_r - 2'd1;
        default: count_next_s = count_r;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r      <= '0;
      count_r   <= 2'd0;
      valid_r   <= 1'b0;
      e0_inst_r <= '0;
      e0_pc_r   <= '0;
      e1_inst_r <= '0;
      e1_pc_r   <= '0;
    end else begin
      pc_r      <= pc_next_s;
      count_r   <= count_next_s;
      valid_r   <= (count_next_s != 2'd0);
      e0_inst_r <= e0_inst_next_s;
      e0_pc_r   <= e0_pc_next_s;
      e1_inst_r <= e1_inst_next_s;
      e1_pc_r   <= e1_pc_next_s;
    end
  end

  assign rom_addr   = pc_r;
  assign inst_valid = valid_r;
  assign inst_out   = e0_inst_r;
  assign inst_pc    = e0_pc_r;
  assign buf_count  = count_r;

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Instruction fetch sequencer for the 16-entry x 16-bit program ROM. It owns the program counter and drives the ROM address. Each ROM word is captured into a 2-entry instruction buffer and presented to the decoder with a valid/ready handshake. It also handles early JMP redirection, execute-stage redirects (taken branches), halting and PC wrap-around.

Parameters:
ADDR_W, 4, program counter / ROM address width
INST_W, 16, instruction width
BUF_DEPTH, 2, instruction buffer entries (fixed at 2; other values unsupported)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
rom_addr  output  ADDR_W  address to program ROM (ROM is combinational, same-cycle data)
rom_inst  input  INST_W  instruction word from ROM at rom_addr
halt  input  1  when 1, no new fetches; buffer continues to drain
redirect_valid  input  1  execute-stage redirect (taken branch / jump) this cycle
redirect_addr  input  ADDR_W  redirect target
inst_valid  output  1  buffer head holds a valid instruction
inst_out  output  INST_W  buffer head instruction
inst_pc  output  ADDR_W  address the head instruction was fetched from
inst_ready  input  1  decoder accepts head when inst_valid & inst_ready
buf_count  output  2  number of occupied buffer entries (0..2)

Behaviour:
- Reset (async assert, sync release): pc=0, buffer empty, buf_count=0, inst_valid=0, inst_out=0, inst_pc=0. rom_addr=pc at all times, so it reads 0 in reset.
- pop = inst_valid & inst_ready.
- fetch = ~halt & ~redirect_valid & (buf_count<2 | pop). When fetch is 1, {pc, rom_inst} is pushed at the tail on the clock edge.
- Next PC, in priority order:
  1. redirect_valid: pc <= redirect_addr.
  2. fetch and rom_inst[15:12]==4'b1000 (JMP): pc <= rom_inst[11:8]. The JMP word is still pushed.
  3. fetch: pc <= pc+1, wrapping 15 -> 0 (modulo 2^ADDR_W).
  4. Otherwise pc holds.
- Redirect flush: on redirect_valid, all buffer entries are discarded and buf_count <= 0 on the edge. If a pop coincides, that head counts as consumed, since the decoder issued the redirect. The next cycle fetches redirect_addr, and inst_valid returns 1 the cycle after that.
- Fetch latency: an instruction at address A presented on rom_addr in cycle N appears at the buffer head no earlier than cycle N+1, when the buffer was empty.
- Throughput: 1 instruction/cycle sustained while inst_ready=1.
- Buffer: FIFO order is preserved. Simultaneous push and pop at buf_count=2 is legal and keeps the count at 2. At buf_count=2 without a pop, no fetch occurs and pc holds.
- Empty: inst_valid=0. inst_out and inst_pc hold their last values (don't-care to the consumer).
- Halt: takes effect the same cycle and blocks the push. Buffered entries still drain normally. Deasserting halt resumes fetching at the held pc. A redirect during halt still flushes and loads pc.
- Branch (opcode 1100) is not predecoded. It is fetched sequentially and resolved by execute through redirect_valid.
- Reset asserted mid-operation clears everything immediately, regardless of handshake state.
- No combinational path from inst_ready or redirect_valid to rom_addr. rom_addr is driven purely by the pc register.

Test Plan:
1. ROM 0..3 = load, load, mov, out; inst_ready=1. Release reset → inst_valid first high at cycle 1 with inst_pc=0. inst_pc then reads 1, 2, 3 on consecutive cycles.
2. ROM[4]=16'h8000 (jmp 0), ROM[5] nonzero → after inst_pc=4 the next head is inst_pc=0. Address 5 is never pushed, and rom_addr goes 4 → 0.
3. inst_ready=0 for 5 cycles from reset → buf_count saturates at 2 holding pc 0, 1, and pc holds at 2. Raising inst_ready delivers 0, 1, 2 in order with no gap.
4. With buf_count=2, pulse redirect_valid with redirect_addr=4'd12 → buf_count=0 and inst_valid=0 next cycle, rom_addr=12. The cycle after that, the head has inst_pc=12.
5. Linear program with no jumps → inst_pc 14, 15, 0, 1 (wrap-around verified).
6. halt=1 with buf_count=2 and inst_ready=1 → two pops, then inst_valid=0 and pc frozen. Release halt → fetch resumes at the frozen pc. Separately, assert rst_n=0 mid-stream → all outputs are zero asynchronously.
